// File: rtl/p_perm_sequencer.sv
// Keyed 8-bit P-permutation sequencer: 1-cycle accept, 4 shift steps, result held in DONE.
// Latency accept-to-valid is 4 edges; the sink stalls the job in DONE and In_ready stays low until it drains.
module p_perm_sequencer #(
  parameter logic [7:0] KEY_RESET = 8'b10_01_00_11
) (
  input  logic       Clk,
  input  logic       Rst_n,
  input  logic [7:0] In,
  input  logic       In_valid,
  output logic       In_ready,
  input  logic [7:0] Key_in,
  input  logic       Key_wr,
  output logic       Key_err,
  output logic [7:0] Out,
  output logic       Out_valid,
  input  logic       Out_ready,
  output logic       Busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] key_q, key_d;
  logic [7:0] shadow_q, shadow_d;
  logic       pending_q, pending_d;
  logic [7:0] byte_q, byte_d;
  logic [7:0] sreg_q, sreg_d;
  logic [7:0] out_q, out_d;
  logic [1:0] step_q, step_d;

  logic [1:0] key_col [4];
  logic [1:0] cur_col;
  logic [1:0] step_pair;

  // Fixed digit-to-column map; a bijection, so a duplicate column means a duplicate digit.
  function automatic logic [1:0] col_of(input logic [1:0] digit);
    logic [1:0] c;
    case (digit)
      2'b00:   c = 2'd2;
      2'b01:   c = 2'd1;
      2'b10:   c = 2'd0;
      default: c = 2'd3;
    endcase
    return c;
  endfunction

  always_comb begin
    for (int j = 0; j < 4; j++) begin
      key_col[j] = col_of(key_q[2*j +: 2]);
    end
  end

  assign Key_err = (key_col[0] == key_col[1]) || (key_col[0] == key_col[2]) ||
                   (key_col[0] == key_col[3]) || (key_col[1] == key_col[2]) ||
                   (key_col[1] == key_col[3]) || (key_col[2] == key_col[3]);

  assign cur_col   = col_of(key_q[{step_q, 1'b0} +: 2]);
  assign step_pair = {byte_q[{1'b0, cur_col}], byte_q[{1'b1, cur_col}]};

  always_comb begin
    state_d   = state_q;
    key_d     = key_q;
    shadow_d  = shadow_q;
    pending_d = pending_q;
    byte_d    = byte_q;
    sreg_d    = sreg_q;
    out_d     = out_q;
    step_d    = step_q;
    In_ready  = 1'b0;

    case (state_q)
      IDLE: begin
        In_ready = !Key_err && !Key_wr && !pending_q;
        if (Key_wr) begin
          key_d     = Key_in;
          pending_d = 1'b0;
        end else if (pending_q) begin
          // Deferred write lands on the first idle edge; no byte is taken in that cycle.
          key_d     = shadow_q;
          pending_d = 1'b0;
        end else if (In_valid && In_ready) begin
          byte_d  = In;
          step_d  = 2'd0;
          state_d = SHIFT;
        end
      end

      SHIFT: begin
        sreg_d = {sreg_q[5:0], step_pair};
        step_d = step_q + 2'd1;
        if (step_q == 2'd3) begin
          out_d   = {sreg_q[5:0], step_pair};
          state_d = DONE;
        end
      end

      DONE: begin
        if (Out_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // The running job keeps its key; writes made while busy wait in the shadow, last one wins.
    if (Key_wr && (state_q != IDLE)) begin
      shadow_d  = Key_in;
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q   <= IDLE;
      key_q     <= KEY_RESET;
      shadow_q  <= 8'h00;
      pending_q <= 1'b0;
      byte_q    <= 8'h00;
      sreg_q    <= 8'h00;
      out_q     <= 8'h00;
      step_q    <= 2'd0;
    end else begin
      state_q   <= state_d;
      key_q     <= key_d;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
      byte_q    <= byte_d;
      sreg_q    <= sreg_d;
      out_q     <= out_d;
      step_q    <= step_d;
    end
  end

  assign Out       = out_q;
  assign Out_valid = (state_q == DONE);
  assign Busy      = (state_q != IDLE);

endmodule

// File: tb/tb_p_perm_sequencer.sv
// Scoreboard bench for p_perm_sequencer: expected bytes are queued at accept and compared when Out_valid rises.
module tb_p_perm_sequencer;

  logic       Clk = 1'b0;
  logic       Rst_n;
  logic [7:0] In;
  logic       In_valid;
  logic       In_ready;
  logic [7:0] Key_in;
  logic       Key_wr;
  logic       Key_err;
  logic [7:0] Out;
  logic       Out_valid;
  logic       Out_ready;
  logic       Busy;

  int total = 0;
  int bad   = 0;
  logic [7:0] key_model;
  logic [7:0] sb [$];

  p_perm_sequencer #(.KEY_RESET(8'h93)) dut (
    .Clk       (Clk),
    .Rst_n     (Rst_n),
    .In        (In),
    .In_valid  (In_valid),
    .In_ready  (In_ready),
    .Key_in    (Key_in),
    .Key_wr    (Key_wr),
    .Key_err   (Key_err),
    .Out       (Out),
    .Out_valid (Out_valid),
    .Out_ready (Out_ready),
    .Busy      (Busy)
  );

  always #5 Clk = ~Clk;

  // Reference: result pair j (MSB first) = {b[c], b[c+4]} with c from key digit j.
  function automatic logic [7:0] perm(input logic [7:0] b, input logic [7:0] k);
    logic [7:0] r;
    logic [1:0] d;
    int c;
    r = 8'h00;
    for (int j = 0; j < 4; j++) begin
      d = k[2*j +: 2];
      c = (d == 2'b00) ? 2 : (d == 2'b01) ? 1 : (d == 2'b10) ? 0 : 3;
      r[7-2*j]   = b[c];
      r[6-2*j]   = b[c+4];
    end
    return r;
  endfunction

  function automatic bit key_bad(input logic [7:0] k);
    bit dup;
    dup = 1'b0;
    for (int a = 0; a < 4; a++)
      for (int b = a + 1; b < 4; b++)
        if (k[2*a +: 2] == k[2*b +: 2]) dup = 1'b1;
    return dup;
  endfunction

  task automatic send_byte(input logic [7:0] b);
    int n;
    bit ok;
    n = 0;
    ok = 1'b0;
    In = b;
    In_valid = 1'b1;
    while (n < 50) begin
      @(negedge Clk);
      if (In_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
      n++;
    end
    @(posedge Clk);
    #1;
    In_valid = 1'b0;
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL accept_timeout: byte %h never accepted, In_ready=%b required 1", b, In_ready);
    end else begin
      sb.push_back(perm(b, key_model));
    end
  endtask

  task automatic wait_valid(output int lat);
    bit ok;
    lat = 0;
    ok = 1'b0;
    while (lat < 50) begin
      @(negedge Clk);
      if (Out_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
      lat++;
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL valid_timeout: Out_valid=%b required 1 within 50 cycles", Out_valid);
    end
  endtask

  task automatic write_key(input logic [7:0] k);
    Key_in = k;
    Key_wr = 1'b1;
    @(posedge Clk);
    #1;
    Key_wr = 1'b0;
  endtask

  task automatic test_reset();
    Rst_n = 1'b0;
    In = 8'h00; In_valid = 1'b0; Key_in = 8'h00; Key_wr = 1'b0; Out_ready = 1'b1;
    key_model = 8'h93;
    #12;
    total++; if (Out !== 8'h00)     begin bad++; $display("FAIL reset_out: got %h want 00", Out); end
    total++; if (Out_valid !== 1'b0) begin bad++; $display("FAIL reset_vld: got %b want 0", Out_valid); end
    total++; if (Busy !== 1'b0)     begin bad++; $display("FAIL reset_busy: got %b want 0", Busy); end
    total++; if (Key_err !== 1'b0)  begin bad++; $display("FAIL reset_keyerr: got %b want 0", Key_err); end
    Rst_n = 1'b1;
    @(negedge Clk);
    total++; if (In_ready !== 1'b1) begin bad++; $display("FAIL reset_rdy: got %b want 1", In_ready); end
  endtask

  task automatic test_default_key();
    int lat;
    logic [7:0] exp;
    @(posedge Clk); #1;
    send_byte(8'hA5);
    wait_valid(lat);
    exp = sb.pop_front();
    total++; if (lat != 4)      begin bad++; $display("FAIL dflt_latency: got %0d want 4", lat); end
    total++; if (Out !== exp)   begin bad++; $display("FAIL dflt_sb: got %h want %h", Out, exp); end
    total++; if (Out !== 8'h66) begin bad++; $display("FAIL dflt_out: got %h want 66", Out); end
    @(negedge Clk);
    total++; if (Out_valid !== 1'b0) begin bad++; $display("FAIL dflt_vld_pulse: got %b want 0", Out_valid); end
    total++; if (Busy !== 1'b0)      begin bad++; $display("FAIL dflt_busy: got %b want 0", Busy); end
    total++; if (Out !== 8'h66)      begin bad++; $display("FAIL dflt_out_hold: got %h want 66", Out); end
  endtask

  task automatic test_key_write();
    int lat;
    logic [7:0] exp;
    @(posedge Clk); #1;
    In = 8'hF0; In_valid = 1'b1; Key_in = 8'hC6; Key_wr = 1'b1;
    @(negedge Clk);
    total++; if (In_ready !== 1'b0) begin bad++; $display("FAIL kw_rdy_block: got %b want 0", In_ready); end
    @(posedge Clk); #1;
    Key_wr = 1'b0; In_valid = 1'b0;
    key_model = 8'hC6;
    @(negedge Clk);
    total++; if (Busy !== 1'b0)     begin bad++; $display("FAIL kw_not_taken: Busy got %b want 0", Busy); end
    total++; if (In_ready !== 1'b1) begin bad++; $display("FAIL kw_rdy_after: got %b want 1", In_ready); end
    @(posedge Clk); #1;
    send_byte(8'hF0);
    wait_valid(lat);
    exp = sb.pop_front();
    total++; if (Out !== exp)   begin bad++; $display("FAIL kw_sb: got %h want %h", Out, exp); end
    total++; if (Out !== 8'h55) begin bad++; $display("FAIL kw_out: got %h want 55", Out); end
    @(posedge Clk); #1;
    send_byte(8'hA5);
    wait_valid(lat);
    exp = sb.pop_front();
    total++; if (Out !== 8'h99) begin bad++; $display("FAIL kw_a5: got %h want 99 (exp %h)", Out, exp); end
    @(posedge Clk); #1;
  endtask

  task automatic test_invalid_key();
    write_key(8'h07);
    In = 8'hA5; In_valid = 1'b1;
    @(negedge Clk);
    total++; if (Key_err !== 1'b1)  begin bad++; $display("FAIL inv_err: got %b want 1", Key_err); end
    total++; if (In_ready !== 1'b0) begin bad++; $display("FAIL inv_rdy: got %b want 0", In_ready); end
    @(negedge Clk);
    total++; if (Busy !== 1'b0)     begin bad++; $display("FAIL inv_busy: got %b want 0", Busy); end
    @(posedge Clk); #1;
    In_valid = 1'b0;
    write_key(8'h93);
    key_model = 8'h93;
    @(negedge Clk);
    total++; if (Key_err !== 1'b0)  begin bad++; $display("FAIL inv_fix_err: got %b want 0", Key_err); end
    total++; if (In_ready !== 1'b1) begin bad++; $display("FAIL inv_fix_rdy: got %b want 1", In_ready); end
    @(posedge Clk); #1;
  endtask

  task automatic test_pending_key();
    int lat;
    logic [7:0] exp;
    send_byte(8'hA5);
    Key_in = 8'hC6; Key_wr = 1'b1;
    @(posedge Clk); #1;
    Key_in = 8'h93;
    @(posedge Clk); #1;
    Key_wr = 1'b0;
    wait_valid(lat);
    exp = sb.pop_front();
    total++; if (Out !== exp)   begin bad++; $display("FAIL pend_sb: got %h want %h", Out, exp); end
    total++; if (Out !== 8'h66) begin bad++; $display("FAIL pend_out: got %h want 66", Out); end
    @(posedge Clk); #1;
    In = 8'hA5; In_valid = 1'b1;
    @(negedge Clk);
    total++; if (In_ready !== 1'b0) begin bad++; $display("FAIL pend_rdy: got %b want 0", In_ready); end
    @(posedge Clk); #1;
    send_byte(8'hA5);
    wait_valid(lat);
    exp = sb.pop_front();
    total++; if (Out !== 8'h66) begin bad++; $display("FAIL pend_newkey: got %h want 66 (exp %h)", Out, exp); end
    @(posedge Clk); #1;
  endtask

  task automatic test_backpressure();
    int lat;
    logic [7:0] exp;
    Out_ready = 1'b0;
    send_byte(8'hA5);
    In = 8'h3C; In_valid = 1'b1;
    wait_valid(lat);
    exp = sb.pop_front();
    total++; if (Out !== exp) begin bad++; $display("FAIL bp_sb: got %h want %h", Out, exp); end
    for (int i = 0; i < 10; i++) begin
      @(negedge Clk);
      total++;
      if (Out_valid !== 1'b1 || Out !== 8'h66 || In_ready !== 1'b0) begin
        bad++;
        $display("FAIL bp_hold[%0d]: vld=%b out=%h rdy=%b want 1/66/0", i, Out_valid, Out, In_ready);
      end
    end
    In_valid = 1'b0;
    Out_ready = 1'b1;
    @(negedge Clk);
    total++; if (Out_valid !== 1'b0) begin bad++; $display("FAIL bp_release_vld: got %b want 0", Out_valid); end
    total++; if (Busy !== 1'b0)      begin bad++; $display("FAIL bp_release_busy: got %b want 0", Busy); end
    @(posedge Clk); #1;
  endtask

  task automatic test_reset_mid_job();
    int lat;
    logic [7:0] exp;
    send_byte(8'hA5);
    Key_in = 8'hC6; Key_wr = 1'b1;
    @(posedge Clk); #1;
    Key_wr = 1'b0;
    @(posedge Clk); #1;
    Rst_n = 1'b0;
    #1;
    void'(sb.pop_back());
    total++; if (Out_valid !== 1'b0) begin bad++; $display("FAIL rst_mid_vld: got %b want 0", Out_valid); end
    total++; if (Busy !== 1'b0)      begin bad++; $display("FAIL rst_mid_busy: got %b want 0", Busy); end
    total++; if (Out !== 8'h00)      begin bad++; $display("FAIL rst_mid_out: got %h want 00", Out); end
    #3;
    Rst_n = 1'b1;
    key_model = 8'h93;
    @(posedge Clk); #1;
    send_byte(8'hA5);
    wait_valid(lat);
    exp = sb.pop_front();
    total++; if (Out !== 8'h66) begin bad++; $display("FAIL rst_mid_next: got %h want 66 (exp %h)", Out, exp); end
    @(posedge Clk); #1;
  endtask

  task automatic test_random_keys();
    int lat;
    logic [7:0] k;
    logic [7:0] b;
    logic [7:0] exp;
    logic [7:0] vk [4];
    vk = '{8'h1B, 8'hE4, 8'h4E, 8'hB1};
    for (int i = 0; i < 8; i++) begin
      k = (i % 2 == 0) ? vk[i/2] : 8'($urandom_range(0, 255));
      write_key(k);
      @(negedge Clk);
      total++;
      if (Key_err !== key_bad(k)) begin
        bad++;
        $display("FAIL rk_err key=%h: got %b want %b", k, Key_err, key_bad(k));
      end
      @(posedge Clk); #1;
      if (!key_bad(k)) begin
        key_model = k;
        b = 8'($urandom_range(0, 255));
        send_byte(b);
        wait_valid(lat);
        exp = sb.pop_front();
        total++; if (Out !== exp) begin bad++; $display("FAIL rk_out key=%h in=%h: got %h want %h", k, b, Out, exp); end
        @(posedge Clk); #1;
      end
    end
    write_key(8'h93);
    key_model = 8'h93;
  endtask

  task automatic test_back_to_back();
    time t [3];
    fork
      begin
        for (int i = 0; i < 3; i++) begin
          send_byte(8'($urandom_range(0, 255)));
          t[i] = $time;
        end
      end
      begin
        int lat;
        logic [7:0] exp;
        for (int i = 0; i < 3; i++) begin
          wait_valid(lat);
          exp = sb.pop_front();
          total++; if (Out !== exp) begin bad++; $display("FAIL b2b_out[%0d]: got %h want %h", i, Out, exp); end
          @(posedge Clk);
        end
      end
    join
    total++; if (t[1] - t[0] != 60) begin bad++; $display("FAIL b2b_period: got %0t want 60", t[1] - t[0]); end
    total++; if (t[2] - t[1] != 60) begin bad++; $display("FAIL b2b_period2: got %0t want 60", t[2] - t[1]); end
    @(posedge Clk); #1;
  endtask

  initial begin
    test_reset();
    test_default_key();
    test_key_write();
    test_invalid_key();
    test_pending_key();
    test_backpressure();
    test_reset_mid_job();
    test_random_keys();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
